// File: rtl/rename.sv
// Register-rename stage: speculative/committed RATs, circular free list with
// committed head for single-cycle flush recovery, one-entry output register.
module rename #(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int FL_DEPTH  = NUM_PREGS - 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fe_valid_i,
  output logic              fe_ready_o,
  input  logic [31:0]       fe_pc_i,
  input  logic [4:0]        fe_rs1_i,
  input  logic [4:0]        fe_rs2_i,
  input  logic [4:0]        fe_rd_i,
  input  logic [31:0]       fe_imm_i,
  input  logic [9:0]        fe_ctrl_i,
  output logic              rn_valid_o,
  input  logic              rn_ready_i,
  output logic [31:0]       rn_pc_o,
  output logic [31:0]       rn_imm_o,
  output logic [9:0]        rn_ctrl_o,
  output logic [PREG_W-1:0] rn_prs1_o,
  output logic [PREG_W-1:0] rn_prs2_o,
  output logic [PREG_W-1:0] rn_prd_o,
  output logic [PREG_W-1:0] rn_old_prd_o,
  input  logic              cm_valid_i,
  input  logic [4:0]        cm_rd_i,
  input  logic [PREG_W-1:0] cm_prd_i,
  input  logic [PREG_W-1:0] cm_old_prd_i,
  input  logic              flush_i
);

  localparam int FL_W  = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CNT_W = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0] spec_rat_r     [32];
  logic [PREG_W-1:0] arch_rat_r     [32];
  logic [PREG_W-1:0] arch_rat_nxt_s [32];
  logic [PREG_W-1:0] fl_mem_r       [FL_DEPTH];
  logic [FL_W-1:0]   head_r;
  logic [FL_W-1:0]   tail_r;
  logic [FL_W-1:0]   commit_head_r;
  logic [FL_W-1:0]   commit_head_nxt_s;
  logic [CNT_W-1:0]  fl_count_r;
  logic              accept_s;
  logic              alloc_s;
  logic [PREG_W-1:0] prs1_s;
  logic [PREG_W-1:0] prs2_s;

  function automatic logic [FL_W-1:0] ptr_inc(input logic [FL_W-1:0] p);
    if (p == FL_W'(FL_DEPTH - 1)) begin
      return {FL_W{1'b0}};
    end else begin
      return p + FL_W'(1);
    end
  endfunction

  assign fe_ready_o = reset && !flush_i && (!rn_valid_o || rn_ready_i) &&
                      (fl_count_r != CNT_W'(0));
  assign accept_s   = fe_valid_i && fe_ready_o;
  assign alloc_s    = accept_s && fe_ctrl_i[1] && (fe_rd_i != 5'd0);

  // Source lookup plus post-commit view of the committed state used by flush.
  always_comb begin
    arch_rat_nxt_s = arch_rat_r;
    if (cm_valid_i && (cm_rd_i != 5'd0)) begin
      arch_rat_nxt_s[cm_rd_i] = cm_prd_i;
    end else begin
      arch_rat_nxt_s = arch_rat_r;
    end
    if (cm_valid_i) begin
      commit_head_nxt_s = ptr_inc(commit_head_r);
    end else begin
      commit_head_nxt_s = commit_head_r;
    end
    if (fe_rs1_i == 5'd0) begin
      prs1_s = {PREG_W{1'b0}};
    end else begin
      prs1_s = spec_rat_r[fe_rs1_i];
    end
    if (fe_rs2_i == 5'd0) begin
      prs2_s = {PREG_W{1'b0}};
    end else begin
      prs2_s = spec_rat_r[fe_rs2_i];
    end
  end

  // Rename state, free list and output register; flush overrides allocation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_rat_r[i] <= PREG_W'(i);
        arch_rat_r[i] <= PREG_W'(i);
      end
      for (int j = 0; j < FL_DEPTH; j++) begin
        fl_mem_r[j] <= PREG_W'(32 + j);
      end
      head_r        <= {FL_W{1'b0}};
      tail_r        <= {FL_W{1'b0}};
      commit_head_r <= {FL_W{1'b0}};
      fl_count_r    <= CNT_W'(FL_DEPTH);
      rn_valid_o    <= 1'b0;
      rn_pc_o       <= 32'd0;
      rn_imm_o      <= 32'd0;
      rn_ctrl_o     <= 10'd0;
      rn_prs1_o     <= {PREG_W{1'b0}};
      rn_prs2_o     <= {PREG_W{1'b0}};
      rn_prd_o      <= {PREG_W{1'b0}};
      rn_old_prd_o  <= {PREG_W{1'b0}};
    end else begin
      arch_rat_r    <= arch_rat_nxt_s;
      commit_head_r <= commit_head_nxt_s;
      if (cm_valid_i) begin
        fl_mem_r[tail_r] <= cm_old_prd_i;
        tail_r           <= ptr_inc(tail_r);
      end
      if (flush_i) begin
        spec_rat_r <= arch_rat_nxt_s;
        head_r     <= commit_head_nxt_s;
        fl_count_r <= CNT_W'(FL_DEPTH);
        rn_valid_o <= 1'b0;
      end else begin
        if (alloc_s) begin
          spec_rat_r[fe_rd_i] <= fl_mem_r[head_r];
          head_r              <= ptr_inc(head_r);
        end
        fl_count_r <= fl_count_r + CNT_W'(cm_valid_i) - CNT_W'(alloc_s);
        if (accept_s) begin
          rn_valid_o   <= 1'b1;
          rn_pc_o      <= fe_pc_i;
          rn_imm_o     <= fe_imm_i;
          rn_ctrl_o    <= fe_ctrl_i;
          rn_prs1_o    <= prs1_s;
          rn_prs2_o    <= prs2_s;
          rn_prd_o     <= alloc_s ? fl_mem_r[head_r] : {PREG_W{1'b0}};
          rn_old_prd_o <= alloc_s ? spec_rat_r[fe_rd_i] : {PREG_W{1'b0}};
        end else if (rn_ready_i) begin
          rn_valid_o <= 1'b0;
        end
      end
    end
  end

  rename_chk #(.PREG_W(PREG_W)) u_chk (
    .clk           (clk),
    .reset         (reset),
    .cm_valid_i    (cm_valid_i),
    .cm_prd_i      (cm_prd_i),
    .commit_tag_s  (fl_mem_r[commit_head_r])
  );

endmodule

// Retirement must release tags in allocation order.
module rename_chk #(
  parameter int PREG_W = 6
) (
  input logic              clk,
  input logic              reset,
  input logic              cm_valid_i,
  input logic [PREG_W-1:0] cm_prd_i,
  input logic [PREG_W-1:0] commit_tag_s
);
  a_commit_order: assert property (@(posedge clk) disable iff (!reset)
    cm_valid_i |-> (cm_prd_i == commit_tag_s));
endmodule

// File: tb/tb_rename.sv
// Directed self-checking bench for the rename stage.
module tb_rename;
  logic        clk = 1'b0;
  logic        reset;
  logic        fe_valid_i;
  logic        fe_ready_o;
  logic [31:0] fe_pc_i;
  logic [4:0]  fe_rs1_i, fe_rs2_i, fe_rd_i;
  logic [31:0] fe_imm_i;
  logic [9:0]  fe_ctrl_i;
  logic        rn_valid_o;
  logic        rn_ready_i;
  logic [31:0] rn_pc_o, rn_imm_o;
  logic [9:0]  rn_ctrl_o;
  logic [5:0]  rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o;
  logic        cm_valid_i;
  logic [4:0]  cm_rd_i;
  logic [5:0]  cm_prd_i, cm_old_prd_i;
  logic        flush_i;

  int tests = 0;
  int fails = 0;

  localparam logic [9:0] CTRL_RW = 10'b00_0000_0010;
  localparam logic [9:0] CTRL_ST = 10'b00_0000_0100;

  always #5 clk = ~clk;

  rename dut (
    .clk(clk), .reset(reset),
    .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o), .fe_pc_i(fe_pc_i),
    .fe_rs1_i(fe_rs1_i), .fe_rs2_i(fe_rs2_i), .fe_rd_i(fe_rd_i),
    .fe_imm_i(fe_imm_i), .fe_ctrl_i(fe_ctrl_i),
    .rn_valid_o(rn_valid_o), .rn_ready_i(rn_ready_i),
    .rn_pc_o(rn_pc_o), .rn_imm_o(rn_imm_o), .rn_ctrl_o(rn_ctrl_o),
    .rn_prs1_o(rn_prs1_o), .rn_prs2_o(rn_prs2_o),
    .rn_prd_o(rn_prd_o), .rn_old_prd_o(rn_old_prd_o),
    .cm_valid_i(cm_valid_i), .cm_rd_i(cm_rd_i),
    .cm_prd_i(cm_prd_i), .cm_old_prd_i(cm_old_prd_i),
    .flush_i(flush_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [9:0] ctrl);
    fe_valid_i = v; fe_pc_i = pc; fe_rs1_i = rs1; fe_rs2_i = rs2;
    fe_rd_i = rd; fe_imm_i = imm; fe_ctrl_i = ctrl;
  endtask

  task automatic do_reset();
    reset = 1'b0; rn_ready_i = 1'b1; cm_valid_i = 1'b0; cm_rd_i = 5'd0;
    cm_prd_i = 6'd0; cm_old_prd_i = 6'd0; flush_i = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    drive(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, 32'd0, CTRL_RW);
    #1;
    tests++; if (fe_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", fe_ready_o); end
    tick();
    tests++; if (rn_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rn_valid_o); end
    tests++; if ({rn_pc_o, rn_prd_o, rn_old_prd_o} !== 44'd0) begin fails++; $display("FAIL reset_data: pc %h prd %0d old %0d want 0", rn_pc_o, rn_prd_o, rn_old_prd_o); end
    reset = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    #1;
    tests++; if (fe_ready_o !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", fe_ready_o); end
  endtask

  task automatic test_rename_chain();
    do_reset();
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h55, CTRL_RW);
    tick();
    drive(1'b1, 32'h104, 5'd5, 5'd0, 5'd5, 32'h66, CTRL_RW);
    tests++; if ({rn_valid_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o} !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd5})
      begin fails++; $display("FAIL first_rename: v %b prs1 %0d prs2 %0d prd %0d old %0d want 1/1/2/32/5", rn_valid_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o); end
    tests++; if ({rn_pc_o, rn_imm_o, rn_ctrl_o} !== {32'h100, 32'h55, CTRL_RW})
      begin fails++; $display("FAIL passthrough: pc %h imm %h ctrl %b want 100/55/%b", rn_pc_o, rn_imm_o, rn_ctrl_o, CTRL_RW); end
    tick();
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tests++; if ({rn_valid_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o} !== {1'b1, 6'd32, 6'd0, 6'd33, 6'd32})
      begin fails++; $display("FAIL dep_chain: v %b prs1 %0d prs2 %0d prd %0d old %0d want 1/32/0/33/32", rn_valid_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o); end
    tick();
    tests++; if (rn_valid_o !== 1'b0) begin fails++; $display("FAIL drain: got %b want 0", rn_valid_o); end
  endtask

  // Continues from the chain: x5->33, two tags used.
  task automatic test_no_alloc();
    drive(1'b1, 32'h200, 5'd5, 5'd0, 5'd0, 32'd0, CTRL_RW);
    tick();
    drive(1'b1, 32'h204, 5'd5, 5'd6, 5'd7, 32'd8, CTRL_ST);
    tests++; if ({rn_prs1_o, rn_prd_o, rn_old_prd_o} !== {6'd33, 6'd0, 6'd0})
      begin fails++; $display("FAIL rd0: prs1 %0d prd %0d old %0d want 33/0/0", rn_prs1_o, rn_prd_o, rn_old_prd_o); end
    tick();
    drive(1'b1, 32'h208, 5'd7, 5'd0, 5'd6, 32'd0, CTRL_RW);
    tests++; if ({rn_valid_o, rn_prd_o, rn_old_prd_o} !== {1'b1, 6'd0, 6'd0})
      begin fails++; $display("FAIL store: v %b prd %0d old %0d want 1/0/0", rn_valid_o, rn_prd_o, rn_old_prd_o); end
    tests++; if (dut.fl_count_r !== 6'd30) begin fails++; $display("FAIL count_noalloc: got %0d want 30", dut.fl_count_r); end
    tick();
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tests++; if ({rn_prs1_o, rn_prd_o, rn_old_prd_o} !== {6'd7, 6'd34, 6'd6})
      begin fails++; $display("FAIL alloc_after_noalloc: prs1 %0d prd %0d old %0d want 7/34/6", rn_prs1_o, rn_prd_o, rn_old_prd_o); end
    tick();
  endtask

  task automatic test_exhaust();
    int not_ready;
    do_reset();
    not_ready = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 5'd0, 5'd0, 5'(((i + 4) % 31) + 1), 32'd0, CTRL_RW);
      #1;
      if (fe_ready_o !== 1'b1) not_ready++;
      tick();
    end
    tests++; if (not_ready != 0) begin fails++; $display("FAIL fill_ready: %0d stalls want 0", not_ready); end
    tests++; if ({rn_prd_o, rn_old_prd_o} !== {6'd63, 6'd32})
      begin fails++; $display("FAIL last_alloc: prd %0d old %0d want 63/32", rn_prd_o, rn_old_prd_o); end
    drive(1'b1, 32'h400, 5'd1, 5'd0, 5'd2, 32'd0, CTRL_ST);
    #1;
    tests++; if (fe_ready_o !== 1'b0) begin fails++; $display("FAIL empty_ready: got %b want 0", fe_ready_o); end
    tick();
    cm_valid_i = 1'b1; cm_rd_i = 5'd5; cm_prd_i = 6'd32; cm_old_prd_i = 6'd5;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    #1;
    tests++; if (fe_ready_o !== 1'b0) begin fails++; $display("FAIL no_bypass: got %b want 0", fe_ready_o); end
    tick();
    cm_valid_i = 1'b0;
    drive(1'b1, 32'h500, 5'd5, 5'd0, 5'd9, 32'd0, CTRL_RW);
    #1;
    tests++; if (fe_ready_o !== 1'b1) begin fails++; $display("FAIL recover_ready: got %b want 1", fe_ready_o); end
    tick();
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tests++; if ({rn_prs1_o, rn_prd_o, rn_old_prd_o} !== {6'd63, 6'd5, 6'd36})
      begin fails++; $display("FAIL recycled_tag: prs1 %0d prd %0d old %0d want 63/5/36", rn_prs1_o, rn_prd_o, rn_old_prd_o); end
    tick();
  endtask

  task automatic test_backpressure();
    int unstable, ready_hi;
    do_reset();
    rn_ready_i = 1'b0;
    drive(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 32'hA, CTRL_RW);
    tick();
    drive(1'b1, 32'h604, 5'd3, 5'd0, 5'd4, 32'hB, CTRL_RW);
    unstable = 0; ready_hi = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (fe_ready_o !== 1'b0) ready_hi++;
      if ({rn_valid_o, rn_pc_o, rn_imm_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o} !==
          {1'b1, 32'h600, 32'hA, 6'd1, 6'd2, 6'd32, 6'd3}) unstable++;
      tick();
    end
    tests++; if (ready_hi != 0) begin fails++; $display("FAIL bp_ready: %0d cycles ready want 0", ready_hi); end
    tests++; if (unstable != 0) begin fails++; $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); end
    rn_ready_i = 1'b1;
    #1;
    tests++; if (fe_ready_o !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", fe_ready_o); end
    tick();
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tests++; if ({rn_valid_o, rn_pc_o, rn_prs1_o, rn_prd_o, rn_old_prd_o} !== {1'b1, 32'h604, 6'd32, 6'd33, 6'd4})
      begin fails++; $display("FAIL bp_next: v %b pc %h prs1 %0d prd %0d old %0d want 1/604/32/33/4", rn_valid_o, rn_pc_o, rn_prs1_o, rn_prd_o, rn_old_prd_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 5; r <= 7; r++) begin
      drive(1'b1, 32'h700, 5'd0, 5'd0, 5'(r), 32'd0, CTRL_RW);
      tick();
    end
    cm_valid_i = 1'b1; cm_rd_i = 5'd5; cm_prd_i = 6'd32; cm_old_prd_i = 6'd5; flush_i = 1'b1;
    drive(1'b1, 32'h7FF, 5'd0, 5'd0, 5'd8, 32'd0, CTRL_RW);
    #1;
    tests++; if (fe_ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", fe_ready_o); end
    tick();
    cm_valid_i = 1'b0; flush_i = 1'b0;
    drive(1'b1, 32'h800, 5'd5, 5'd6, 5'd9, 32'd0, CTRL_RW);
    tests++; if (rn_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", rn_valid_o); end
    tests++; if (dut.fl_count_r !== 6'd32) begin fails++; $display("FAIL flush_count: got %0d want 32", dut.fl_count_r); end
    tick();
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 10'd0);
    tests++; if ({rn_valid_o, rn_pc_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o} !== {1'b1, 32'h800, 6'd32, 6'd6, 6'd33, 6'd9})
      begin fails++; $display("FAIL post_flush: v %b pc %h prs1 %0d prs2 %0d prd %0d old %0d want 1/800/32/6/33/9", rn_valid_o, rn_pc_o, rn_prs1_o, rn_prs2_o, rn_prd_o, rn_old_prd_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_rename_chain();
    test_no_alloc();
    test_exhaust();
    test_backpressure();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
